// File: rtl/wdb_pkg.sv
// Shared types for the posted-write drain buffer: the queued entry layout and the drain FSM states.
package wdb_pkg;

   localparam int unsigned WDB_WORD_SIZE = 32;

   typedef struct packed {
      logic [WDB_WORD_SIZE-1:0] addr;
      logic [WDB_WORD_SIZE-1:0] data;
   } wdb_entry_t;

   typedef enum logic {
      WDB_IDLE,
      WDB_BUSY
   } wdb_state_t;

endpackage

// File: rtl/wdb_match.sv
// Youngest-match address search over the circular entry array, ordered by age from rd_ptr.
// With SKIP_HEAD set, the in-flight head entry is never reported as a match.
module wdb_match
   import wdb_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter bit          SKIP_HEAD = 1'b0
) (
   input  wdb_entry_t                 entries [DEPTH],
   input  logic [WDB_WORD_SIZE-1:0]   key,
   input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
   input  logic [$clog2(DEPTH):0]     count,
   output logic                       hit,
   output logic [$clog2(DEPTH)-1:0]   idx
);

   localparam int unsigned PW = $clog2(DEPTH);

   // Scan oldest to youngest; the last match assigned is the youngest one.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int unsigned age = 0; age < DEPTH; age++) begin
         if (((PW+1)'(age) < count) && !(SKIP_HEAD && (age == 0)) &&
             (entries[rd_ptr + PW'(age)].addr == key)) begin
            hit = 1'b1;
            idx = rd_ptr + PW'(age);
         end
      end
   end

endmodule

// File: rtl/write_drain_buffer.sv
// Posted-write buffer: accepts controller writes, coalesces onto queued non-head entries,
// forwards youngest queued data to reads, and drains in order to memory over req/ack.
module write_drain_buffer
   import wdb_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WDB_WORD_SIZE,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WORD_SIZE-1:0]   addr,
   input  logic [WORD_SIZE-1:0]   data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   input  logic [WORD_SIZE-1:0]   rd_addr,
   output logic                   fwd_hit,
   output logic [WORD_SIZE-1:0]   fwd_data,
   output logic                   mem_wr_en,
   output logic [WORD_SIZE-1:0]   mem_addr,
   output logic [WORD_SIZE-1:0]   mem_data,
   input  logic                   mem_ack
);

   localparam int unsigned PW = $clog2(DEPTH);

   wdb_entry_t          entries_q [DEPTH];
   wdb_entry_t          entries_d [DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PW:0]         count_q, count_d;
   logic                full_q;
   wdb_state_t          state_q, state_d;
   logic                mem_wr_en_q;
   logic [WORD_SIZE-1:0] mem_addr_q, mem_data_q;
   wdb_entry_t          head_d;

   logic                push_ok, pop, coalesce, append;
   logic                lk_hit, co_hit;
   logic [PW-1:0]       lk_idx, co_idx;

   wdb_match #(
      .DEPTH     (DEPTH),
      .SKIP_HEAD (1'b0)
   ) u_lookup (
      .entries (entries_q),
      .key     (rd_addr),
      .rd_ptr  (rd_ptr_q),
      .count   (count_q),
      .hit     (lk_hit),
      .idx     (lk_idx)
   );

   wdb_match #(
      .DEPTH     (DEPTH),
      .SKIP_HEAD (1'b1)
   ) u_coalesce (
      .entries (entries_q),
      .key     (addr),
      .rd_ptr  (rd_ptr_q),
      .count   (count_q),
      .hit     (co_hit),
      .idx     (co_idx)
   );

   assign push_ok  = wr_en & ~full_q;
   assign pop      = mem_ack & (state_q == WDB_BUSY);
   assign coalesce = push_ok & co_hit;
   assign append   = push_ok & ~co_hit;

   always_comb begin
      entries_d = entries_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (coalesce) begin
         entries_d[co_idx].data = data;
      end
      if (append) begin
         entries_d[wr_ptr_q] = '{addr: addr, data: data};
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({append, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      state_d = (count_d != '0) ? WDB_BUSY : WDB_IDLE;
      // Head cannot change under a pending request: coalesce skips it, append needs count==0.
      head_d  = entries_d[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         state_q     <= WDB_IDLE;
         mem_wr_en_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == (PW+1)'(DEPTH));
         state_q  <= state_d;
         unique case (state_d)
            WDB_BUSY: begin
               mem_wr_en_q <= 1'b1;
               mem_addr_q  <= head_d.addr;
               mem_data_q  <= head_d.data;
            end
            default: begin
               mem_wr_en_q <= 1'b0;
               mem_addr_q  <= '0;
               mem_data_q  <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

   assign full      = full_q;
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign fwd_hit   = lk_hit;
   assign fwd_data  = lk_hit ? entries_q[lk_idx].data : '0;
   assign mem_wr_en = mem_wr_en_q;
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;

endmodule

// File: tb/tb_write_drain_buffer.sv
// Directed bench for write_drain_buffer; drained memory writes are checked by a scoreboard monitor.
module tb_write_drain_buffer;

   logic        clk = 1'b0;
   logic        rst, wr_en, mem_ack;
   logic [31:0] addr, data, rd_addr;
   logic        full, empty, fwd_hit, mem_wr_en;
   logic [2:0]  count;
   logic [31:0] fwd_data, mem_addr, mem_data;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_cmp = 0;
   int  n_bad = 0;

   always #5 clk = ~clk;

   write_drain_buffer #(
      .WORD_SIZE (32),
      .DEPTH     (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .addr      (addr),
      .data      (data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .rd_addr   (rd_addr),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ack   (mem_ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1;
      addr  = a;
      data  = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic exp_push(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic ack();
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 16 && !empty; i++) begin
         ack();
         step();
      end
      check("drain_empty", empty, 1);
      check("drain_mem_wr_en", mem_wr_en, 0);
   endtask

   // Monitor: every accepted memory write is compared with the oldest expected one.
   always @(negedge clk) begin
      if (!rst && mem_wr_en && mem_ack) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_unexpected: got addr %h data %h, required no write",
                     mem_addr, mem_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("drain_addr", mem_addr, mon_e.a);
            check("drain_data", mem_data, mon_e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; mem_ack = 1'b0;
      addr = '0; data = '0; rd_addr = '0;
      step();
      step();
      rst = 1'b0;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_mem_wr_en", mem_wr_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_fwd_hit", fwd_hit, 0);

      // T1: single write, late ack
      exp_push(32'h10, 32'hA5A5A5A5);
      push(32'h10, 32'hA5A5A5A5);
      check("t1_mem_wr_en", mem_wr_en, 1);
      check("t1_mem_addr", mem_addr, 32'h10);
      check("t1_mem_data", mem_data, 32'hA5A5A5A5);
      check("t1_count", count, 1);
      step();
      step();
      check("t1_hold_addr", mem_addr, 32'h10);
      ack();
      check("t1_empty", empty, 1);
      check("t1_idle", mem_wr_en, 0);
      check("t1_idle_addr", mem_addr, 0);

      // T2: fill to full, stalled pushes, pop under full
      exp_push(32'h10, 32'h11);
      exp_push(32'h20, 32'h22);
      exp_push(32'h30, 32'h33);
      exp_push(32'h40, 32'h44);
      push(32'h10, 32'h11);
      push(32'h20, 32'h22);
      push(32'h30, 32'h33);
      check("t2_not_full", full, 0);
      push(32'h40, 32'h44);
      check("t2_full", full, 1);
      check("t2_count4", count, 4);
      push(32'h50, 32'h55);
      check("t2_drop_count", count, 4);
      check("t2_drop_head", mem_addr, 32'h10);
      wr_en = 1'b1; addr = 32'h50; data = 32'h55;
      ack();
      wr_en = 1'b0;
      check("t2_pop_count", count, 3);
      check("t2_pop_full", full, 0);
      check("t2_next_head", mem_addr, 32'h20);
      check("t2_busy", mem_wr_en, 1);
      drain();

      // T3: coalesce onto a non-head entry
      exp_push(32'h10, 32'h1);
      exp_push(32'h20, 32'h2222);
      push(32'h10, 32'h1);
      push(32'h20, 32'h1111);
      push(32'h20, 32'h2222);
      check("t3_count", count, 2);
      rd_addr = 32'h20;
      #1;
      check("t3_fwd_data", fwd_data, 32'h2222);
      drain();

      // T4: head match appends, forwarding youngest, no same-cycle bypass
      exp_push(32'h10, 32'hAAAA);
      exp_push(32'h10, 32'hBBBB);
      exp_push(32'h77, 32'h7777);
      push(32'h10, 32'hAAAA);
      push(32'h10, 32'hBBBB);
      check("t4_count", count, 2);
      rd_addr = 32'h10;
      #1;
      check("t4_fwd_hit", fwd_hit, 1);
      check("t4_fwd_data", fwd_data, 32'hBBBB);
      rd_addr = 32'h11;
      #1;
      check("t4_miss_hit", fwd_hit, 0);
      check("t4_miss_data", fwd_data, 0);
      rd_addr = 32'h77;
      wr_en = 1'b1; addr = 32'h77; data = 32'h7777;
      #1;
      check("t4_no_bypass", fwd_hit, 0);
      step();
      wr_en = 1'b0;
      check("t4_fwd_new_hit", fwd_hit, 1);
      check("t4_fwd_new_data", fwd_data, 32'h7777);
      check("t4_count3", count, 3);
      drain();

      // T5: push and pop together with one entry queued
      exp_push(32'h20, 32'h5);
      exp_push(32'h30, 32'h3333);
      push(32'h20, 32'h5);
      check("t5_busy", mem_wr_en, 1);
      wr_en = 1'b1; addr = 32'h30; data = 32'h3333;
      ack();
      wr_en = 1'b0;
      check("t5_count", count, 1);
      check("t5_mem_wr_en", mem_wr_en, 1);
      check("t5_mem_addr", mem_addr, 32'h30);
      check("t5_mem_data", mem_data, 32'h3333);
      drain();

      // T6: reset while draining drops everything
      push(32'h40, 32'h4);
      push(32'h50, 32'h5);
      push(32'h60, 32'h6);
      rd_addr = 32'h50;
      #1;
      check("t6_pre_count", count, 3);
      check("t6_pre_fwd", fwd_hit, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_count", count, 0);
      check("t6_empty", empty, 1);
      check("t6_mem_wr_en", mem_wr_en, 0);
      check("t6_fwd_hit", fwd_hit, 0);

      check("scoreboard_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
